// File: rtl/rle_pixel_gen_if.sv
// RLE word stream between the upstream source and rle_pixel_gen.
// The master drives words; the slave returns ready and the frame-restart pulse.
interface rle_pixel_gen_if #(
    parameter int unsigned RUN_BITS   = 10,
    parameter int unsigned COLOR_BITS = 6
);
    logic [RUN_BITS+COLOR_BITS-1:0] in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic                           frame_start;

    modport master (
        output in_data, in_valid,
        input  in_ready, frame_start
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, frame_start
    );
endinterface

// File: rtl/rle_pixel_gen.sv
// Run-length-decoding pixel stage behind the VGA timing generator.
// Define RLE_UNDERRUN_CNT_EN to add the per-frame saturating underrun_cnt output.
module rle_pixel_gen #(
    parameter int unsigned RUN_BITS   = 10,
    parameter int unsigned COLOR_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  blank,
    input  logic                  vsync_pulse,
    rle_pixel_gen_if.slave        up,
    output logic [COLOR_BITS-1:0] rgb,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  underrun
`ifdef RLE_UNDERRUN_CNT_EN
    ,
    output logic [7:0]            underrun_cnt
`endif
);

    localparam int unsigned W = RUN_BITS + COLOR_BITS;

    typedef enum logic {S_SYNC, S_ACTIVE} state_t;

    state_t                state, state_n;
    logic [RUN_BITS-1:0]   cnt, cnt_n;
    logic [COLOR_BITS-1:0] col, col_n, rgb_n;
    logic                  cur_v, cur_v_n;
    logic [W-1:0]          buf_q, buf_n;
    logic                  buf_v, buf_v_n;
    logic                  underrun_n;
    logic                  pop, push, starve;
    logic [RUN_BITS-1:0]   buf_len;
    logic [COLOR_BITS-1:0] buf_col;

    assign buf_len = buf_q[W-1:COLOR_BITS];
    assign buf_col = buf_q[COLOR_BITS-1:0];

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        col_n          = col;
        cur_v_n        = cur_v;
        buf_n          = buf_q;
        buf_v_n        = buf_v;
        rgb_n          = '0;
        underrun_n     = underrun;
        pop            = 1'b0;
        push           = 1'b0;
        starve         = 1'b0;
        up.in_ready    = 1'b0;
        up.frame_start = vsync_pulse;

        case (state)
            S_SYNC: begin
                if (vsync_pulse) state_n = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!blank) begin
                    if (cur_v) begin
                        rgb_n = col;
                        if (cnt == '0) begin
                            if (buf_v) begin
                                pop   = 1'b1;
                                cnt_n = buf_len;
                                col_n = buf_col;
                            end else begin
                                cur_v_n = 1'b0;
                            end
                        end else begin
                            cnt_n = cnt - RUN_BITS'(1);
                        end
                    end else if (buf_v) begin
                        // Fresh run shows its first pixel now, so cnt starts one lower.
                        pop   = 1'b1;
                        rgb_n = buf_col;
                        col_n = buf_col;
                        if (buf_len == '0) begin
                            cur_v_n = 1'b0;
                        end else begin
                            cnt_n   = buf_len - RUN_BITS'(1);
                            cur_v_n = 1'b1;
                        end
                    end else begin
                        starve     = 1'b1;
                        underrun_n = 1'b1;
                    end
                end

                up.in_ready = !vsync_pulse && (!buf_v || pop);
                push        = up.in_valid && up.in_ready;
                if (push) begin
                    buf_n   = up.in_data;
                    buf_v_n = 1'b1;
                end else if (pop) begin
                    buf_v_n = 1'b0;
                end

                if (vsync_pulse) begin
                    cur_v_n    = 1'b0;
                    buf_v_n    = 1'b0;
                    underrun_n = starve;
                end
            end
            default: state_n = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_SYNC;
            cnt       <= '0;
            col       <= '0;
            cur_v     <= 1'b0;
            buf_q     <= '0;
            buf_v     <= 1'b0;
            rgb       <= '0;
            underrun  <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            col       <= col_n;
            cur_v     <= cur_v_n;
            buf_q     <= buf_n;
            buf_v     <= buf_v_n;
            rgb       <= rgb_n;
            underrun  <= underrun_n;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

`ifdef RLE_UNDERRUN_CNT_EN
    logic [7:0] urun, urun_n;

    assign urun_n = (starve && urun != 8'hFF) ? urun + 8'd1 : urun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            urun         <= '0;
            underrun_cnt <= '0;
        end else if (vsync_pulse) begin
            underrun_cnt <= urun_n;
            urun         <= '0;
        end else begin
            urun <= urun_n;
        end
    end
`endif

endmodule
